// File: rtl/tx_power_ramp_if.sv
// Sample-side bus for tx_power_ramp: I/Q samples with strobe and burst flag in,
// shaped offset-binary DAC words, RF enable and ramp status/debug out.
interface tx_power_ramp_if #(
  parameter int IN_WIDTH  = 9,
  parameter int DAC_WIDTH = 6,
  parameter int RAMP_LEN  = 16
);
  localparam int GW = $clog2(RAMP_LEN) + 1;

  // No valid/ready handshake here: sample_strobe_i is a one-cycle pulse per sample
  // that is never back-pressured, and iq_valid_i is a level marking the burst.
  logic                        sample_strobe_i;
  logic                        iq_valid_i;
  logic signed [IN_WIDTH-1:0]  inphase_i;
  logic signed [IN_WIDTH-1:0]  quadrature_i;
  logic [DAC_WIDTH-1:0]        dac_i_o;
  logic [DAC_WIDTH-1:0]        dac_q_o;
  logic                        txchain_en_o;
  logic                        ramp_busy_o;
  logic [1:0]                  state_dbg;
  logic [GW-1:0]               gain_dbg;

  modport master (
    output sample_strobe_i, iq_valid_i, inphase_i, quadrature_i,
    input  dac_i_o, dac_q_o, txchain_en_o, ramp_busy_o, state_dbg, gain_dbg
  );

  modport slave (
    input  sample_strobe_i, iq_valid_i, inphase_i, quadrature_i,
    output dac_i_o, dac_q_o, txchain_en_o, ramp_busy_o, state_dbg, gain_dbg
  );
endinterface

// File: rtl/tx_power_ramp.sv
// Burst power shaping: linear gain ramp up/down around iq_valid, truncation to DAC
// width and offset-binary conversion, with an RF enable aligned to the DAC words.
module tx_power_ramp #(
  parameter int IN_WIDTH  = 9,
  parameter int DAC_WIDTH = 6,
  parameter int RAMP_LEN  = 16
) (
  input  logic           pll_clock,
  input  logic           reset,
  tx_power_ramp_if.slave bus
);

  localparam int SH  = $clog2(RAMP_LEN);
  localparam int GW  = SH + 1;
  localparam int PW  = IN_WIDTH + GW + 1;
  localparam int MSB = SH + IN_WIDTH - 1;
  localparam int LSB = MSB - DAC_WIDTH + 1;

  localparam logic [GW-1:0]        GAIN_MAX = GW'(RAMP_LEN);
  localparam logic [DAC_WIDTH-1:0] MID      = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gain, gain_nxt;

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gain  <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
    end
  end

  // A change of iq_valid_i reverses the ramp from the present gain before any limit
  // exit is taken, so abort/retrigger never produces a gain step.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    case (state)
      IDLE: begin
        if (bus.iq_valid_i) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!bus.iq_valid_i)          state_nxt = RAMP_DOWN;
        else if (gain == GAIN_MAX)    state_nxt = HOLD;
        else if (bus.sample_strobe_i) gain_nxt  = gain + 1'b1;
      end
      HOLD: begin
        if (!bus.iq_valid_i) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (bus.iq_valid_i)           state_nxt = RAMP_UP;
        else if (gain == '0)          state_nxt = IDLE;
        else if (bus.sample_strobe_i) gain_nxt  = gain - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        gain_nxt  = '0;
      end
    endcase
  end

  assign bus.ramp_busy_o = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign bus.state_dbg   = state;
  assign bus.gain_dbg    = gain;

  // Stage 1: full-precision product of sample and zero-extended gain.
  logic signed [PW-1:0] x_i_ext, x_q_ext, gain_ext;
  logic signed [PW-1:0] prod_i, prod_q;
  logic                 s1_act;

  assign x_i_ext  = PW'(bus.inphase_i);
  assign x_q_ext  = PW'(bus.quadrature_i);
  assign gain_ext = PW'({1'b0, gain});

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      prod_i <= '0;
      prod_q <= '0;
      s1_act <= 1'b0;
    end else begin
      prod_i <= x_i_ext * gain_ext;
      prod_q <= x_q_ext * gain_ext;
      s1_act <= (state != IDLE);
    end
  end

  // Stage 2: the >>> SH and the DAC-width truncation collapse into one bit slice;
  // flipping the MSB turns two's complement into offset binary.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_i[PW-1:MSB+1], prod_i[LSB-1:0],
                              prod_q[PW-1:MSB+1], prod_q[LSB-1:0]};

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      bus.dac_i_o      <= MID;
      bus.dac_q_o      <= MID;
      bus.txchain_en_o <= 1'b0;
    end else if (s1_act) begin
      bus.dac_i_o      <= prod_i[MSB:LSB] ^ MID;
      bus.dac_q_o      <= prod_q[MSB:LSB] ^ MID;
      bus.txchain_en_o <= 1'b1;
    end else begin
      bus.dac_i_o      <= MID;
      bus.dac_q_o      <= MID;
      bus.txchain_en_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_power_ramp.sv
// Directed bench for tx_power_ramp: ramp up/hold/down, abort, retrigger,
// frozen gain, floor truncation and asynchronous reset.
module tb_tx_power_ramp;
  localparam int IN_WIDTH  = 9;
  localparam int DAC_WIDTH = 6;
  localparam int RAMP_LEN  = 16;

  logic pll_clock = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   failures  = 0;

  tx_power_ramp_if #(.IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH), .RAMP_LEN(RAMP_LEN)) bus ();

  tx_power_ramp #(.IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH), .RAMP_LEN(RAMP_LEN)) dut (
    .pll_clock (pll_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 pll_clock = ~pll_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic strobe_tick();
    bus.sample_strobe_i = 1'b1;
    tick();
    bus.sample_strobe_i = 1'b0;
  endtask

  task automatic chk_dac(input string tag, input int di, input int dq);
    chk({tag, "_dac_i"}, 32'(bus.dac_i_o), di);
    chk({tag, "_dac_q"}, 32'(bus.dac_q_o), dq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sample_strobe_i = 1'b0;
    bus.iq_valid_i      = 1'b0;
    bus.inphase_i       = '0;
    bus.quadrature_i    = '0;

    // reset state
    repeat (3) tick();
    chk_dac("rst", 32, 32);
    chk("rst_en", 32'(bus.txchain_en_o), 0);
    chk("rst_busy", 32'(bus.ramp_busy_o), 0);
    chk("rst_state", 32'(bus.state_dbg), 0);
    chk("rst_gain", 32'(bus.gain_dbg), 0);
    @(negedge pll_clock);
    reset = 1'b0;
    tick();

    // full ramp up, strobe every 4 clocks
    bus.inphase_i    = 9'sd255;
    bus.quadrature_i = -9'sd256;
    bus.iq_valid_i   = 1'b1;
    tick();
    chk("up_state", 32'(bus.state_dbg), 1);
    chk("up_gain0", 32'(bus.gain_dbg), 0);
    chk("up_busy", 32'(bus.ramp_busy_o), 1);
    chk("up_en_e0", 32'(bus.txchain_en_o), 0);
    tick();
    chk("up_en_e1", 32'(bus.txchain_en_o), 0);
    tick();
    chk("up_en_e2", 32'(bus.txchain_en_o), 1);
    chk_dac("up_g0", 32, 32);
    for (int k = 1; k <= 16; k++) begin
      strobe_tick();
      chk("up_gain", 32'(bus.gain_dbg), k);
      repeat (3) tick();
      if (k == 8) chk_dac("up_g8", 47, 16);
    end
    chk("hold_state", 32'(bus.state_dbg), 2);
    chk("hold_busy", 32'(bus.ramp_busy_o), 0);
    chk("hold_en", 32'(bus.txchain_en_o), 1);
    chk_dac("hold_ext", 63, 0);
    strobe_tick();
    chk("hold_gain", 32'(bus.gain_dbg), 16);

    // floor truncation of small values, 2-cycle latency
    bus.inphase_i    = -9'sd1;
    bus.quadrature_i = 9'sd1;
    tick();
    chk_dac("lat_old", 63, 0);
    tick();
    chk_dac("floor", 31, 32);

    // asynchronous reset in HOLD
    bus.inphase_i    = 9'sd255;
    bus.quadrature_i = -9'sd256;
    repeat (2) tick();
    chk_dac("prerst", 63, 0);
    reset          = 1'b1;
    bus.iq_valid_i = 1'b0;
    #1;
    chk_dac("arst", 32, 32);
    chk("arst_en", 32'(bus.txchain_en_o), 0);
    chk("arst_state", 32'(bus.state_dbg), 0);
    chk("arst_gain", 32'(bus.gain_dbg), 0);
    chk("arst_busy", 32'(bus.ramp_busy_o), 0);
    @(negedge pll_clock);
    reset = 1'b0;
    tick();

    // abort at g=5, ramp down to IDLE
    bus.iq_valid_i = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      strobe_tick();
      repeat (3) tick();
    end
    chk("ab_gain5", 32'(bus.gain_dbg), 5);
    bus.iq_valid_i = 1'b0;
    tick();
    chk("ab_state", 32'(bus.state_dbg), 3);
    chk("ab_gain_keep", 32'(bus.gain_dbg), 5);
    chk("ab_busy", 32'(bus.ramp_busy_o), 1);
    for (int k = 4; k >= 1; k--) begin
      strobe_tick();
      chk("ab_gain", 32'(bus.gain_dbg), k);
      repeat (3) tick();
    end
    strobe_tick();
    chk("ab_gain0", 32'(bus.gain_dbg), 0);
    tick();
    chk("ab_idle", 32'(bus.state_dbg), 0);
    chk("ab_idle_busy", 32'(bus.ramp_busy_o), 0);
    chk("ab_en_e0", 32'(bus.txchain_en_o), 1);
    tick();
    chk("ab_en_e1", 32'(bus.txchain_en_o), 1);
    tick();
    chk("ab_en_e2", 32'(bus.txchain_en_o), 0);
    chk_dac("ab_mid", 32, 32);

    // frozen gain in RAMP_UP
    bus.inphase_i    = 9'sd100;
    bus.quadrature_i = -9'sd100;
    bus.iq_valid_i   = 1'b1;
    tick();
    repeat (4) strobe_tick();
    chk("frz_gain4", 32'(bus.gain_dbg), 4);
    repeat (2) tick();
    chk_dac("frz_a", 35, 28);
    bus.inphase_i    = -9'sd200;
    bus.quadrature_i = 9'sd200;
    repeat (2) tick();
    chk_dac("frz_b", 25, 38);
    repeat (10) tick();
    chk("frz_gain", 32'(bus.gain_dbg), 4);
    chk("frz_state", 32'(bus.state_dbg), 1);

    // retrigger during RAMP_DOWN at g=9
    bus.sample_strobe_i = 1'b1;
    repeat (12) tick();
    chk("rt_gain16", 32'(bus.gain_dbg), 16);
    tick();
    chk("rt_hold", 32'(bus.state_dbg), 2);
    bus.iq_valid_i = 1'b0;
    tick();
    chk("rt_down", 32'(bus.state_dbg), 3);
    chk("rt_gain_keep", 32'(bus.gain_dbg), 16);
    for (int k = 15; k >= 9; k--) begin
      tick();
      chk("rt_dn_gain", 32'(bus.gain_dbg), k);
      chk("rt_dn_en", 32'(bus.txchain_en_o), 1);
    end
    bus.iq_valid_i = 1'b1;
    tick();
    chk("rt_up", 32'(bus.state_dbg), 1);
    chk("rt_gain9", 32'(bus.gain_dbg), 9);
    for (int k = 10; k <= 16; k++) begin
      tick();
      chk("rt_up_gain", 32'(bus.gain_dbg), k);
      chk("rt_up_en", 32'(bus.txchain_en_o), 1);
    end
    tick();
    chk("rt_hold2", 32'(bus.state_dbg), 2);
    chk("rt_hold_en", 32'(bus.txchain_en_o), 1);
    bus.sample_strobe_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
